// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO one word at a time and serialises each word as an async
// frame: one start bit (0), WIDTH data bits LSB-first, one stop bit (1).
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int RD_LAT       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             empty,
  output logic             re,
  output logic             txd,
  output logic             busy,
  output logic             done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t           state_reg, state_next;
  logic [BW-1:0]    baud_reg, baud_next;
  logic [CW-1:0]    bit_reg, bit_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic             txd_reg, txd_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  assign txd  = txd_reg;
  assign busy = busy_reg;
  assign done = done_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shreg_reg <= '0;
      txd_reg   <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shreg_reg <= shreg_next;
      txd_reg   <= txd_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shreg_next = shreg_reg;
    re         = (state_reg == IDLE) && !empty && rst;

    case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (re) begin
          if (RD_LAT == 0) begin
            shreg_next = din;
            state_next = START;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        shreg_next = din;
        baud_next  = '0;
        state_next = START;
      end
      START: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      DATA: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next = '0;
          if (bit_reg == BIT_LAST) begin
            state_next = STOP;
          end else begin
            shreg_next = shreg_reg >> 1;
            bit_next   = bit_reg + CW'(1);
          end
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      STOP: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next  = '0;
          state_next = IDLE;
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      default: begin
        baud_next  = '0;
        state_next = IDLE;
      end
    endcase

    // Outputs are registered from the upcoming state so they line up with it.
    busy_next = (state_next != IDLE);
    done_next = (state_next == STOP) && (baud_next == BAUD_LAST);
    txd_next  = 1'b1;
    if (state_next == START) txd_next = 1'b0;
    else if (state_next == DATA) txd_next = shreg_next[0];
  end

endmodule
